deck_controller: RTL and testbench
==================================

# deck_controller

Sequences the 52-card deck datapath for the blackjack game controller. It captures a shuffle seed from how long the seed button is held, then loads the deck storage in rank order. It shuffles the deck in place with an LFSR-driven Fisher-Yates pass and serves one card per request from the game FSM until the deck is exhausted. It sits between the debounced button front end and the game FSM.

## Interface
- DECK_SIZE, 52, number of cards; fixed at 52 for this game.
- RANK_W, 4, width of a card rank (1..13).
- SEED_W, 8, width of the seed counter and LFSR.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- seed_hold  in  1  active-low seed button, already synchronized and debounced.
- req  in  1  active-high card request from the game FSM, one per cycle maximum.
- card  out  RANK_W  rank of the dealt card, 1..13; holds its last value between deals.
- card_valid  out  1  one-cycle pulse; `card` is valid during this cycle.
- ready  out  1  deck shuffled, cards remain.
- busy  out  1  high during LOAD or SHUFFLE.
- empty  out  1  all DECK_SIZE cards dealt.
- cards_left  out  6  cards remaining.

## Operation
- States: IDLE, SEED, LOAD, SHUFFLE, READY, EMPTY.
- IDLE
  - seed_hold sampled low: go to SEED and increment the seed counter.
  - All other inputs are ignored.
- SEED
  - The seed counter increments on every cycle seed_hold is low, wrapping 255 to 0.
  - The first cycle seed_hold is sampled high is the release cycle. Go to LOAD.
  - On entry to LOAD, load the LFSR with the seed. A seed of 0 is replaced by 8'hA5.
- LOAD: one write per cycle, deck[i] = (i mod 13)+1 for i = 0..51, 52 cycles.
- SHUFFLE: one swap per cycle for i = 51 down to 1, 51 cycles.
  - r = current LFSR value; j = r mod (i+1); swap deck[i] and deck[j].
  - Step the LFSR after each swap. LFSR is 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1.
  - Then go to READY and set cards_left = 52 and the read pointer ptr = 0.
- READY
  - On req: the next cycle, card = deck[ptr] and card_valid = 1; ptr increments and cards_left decrements.
  - After the deal that brings cards_left to 0, go to EMPTY.
- EMPTY: only reset leaves this state. req and seed_hold are ignored.
- req outside READY: ignored. No card_valid, no state change.
- seed_hold outside IDLE/SEED: ignored. Reshuffling requires reset.
- Deck storage is a register array of DECK_SIZE × RANK_W. A swap reads and writes both entries in the same cycle.

## Timing
- Reset (async assert, sync release): state IDLE; seed counter 0; ptr 0; deck contents don't-care.
  - Outputs: card 0, card_valid 0, ready 0, busy 0, empty 0, cards_left 0.
- Reset asserted in any state, including mid-LOAD, mid-SHUFFLE or mid-deal, aborts the operation immediately.
- Let release cycle = R:
  - busy is high in cycles R+1..R+103.
  - ready rises and busy falls at R+104.
- Deal latency is 1 cycle from the req sample to card_valid. req on consecutive cycles yields card_valid on consecutive cycles.
- req sampled in the same cycle the 52nd card_valid is high is ignored (state is already EMPTY).
- ready falls and empty rises in the same cycle as the 52nd card_valid.
- cards_left and ptr update in the card_valid cycle.

## Structure
- Shared package blackjack_pkg holds:
  - the state encoding;
  - DECK_SIZE, RANK_W, SEED_W;
  - LFSR tap mask 8'hB8;
  - default seed 8'hA5.
- Sub-module lfsr8 has ports clk, rst, load, seed, step, and output q. Zero-seed substitution is done inside it.
- Everything else (FSM, counters, deck array, swap logic) lives in deck_controller.

## Test plan
- Hold seed_hold low 6 cycles, then release:
  - seed = 6;
  - busy is high for exactly 103 cycles;
  - ready rises at R+104;
  - cards_left = 52.
- Seed 6, then 52 back-to-back req:
  - exactly 52 card_valid pulses;
  - each rank 1..13 appears exactly 4 times;
  - empty = 1 and ready = 0 on the last pulse;
  - a 53rd req produces no pulse.
- Same seed used twice, across a reset: the identical 52-card sequence both times. Seed 7 gives a different sequence.
- Hold low for 256 cycles (seed wraps to 0): the sequence matches an explicit seed of 8'hA5, i.e. hold 165 cycles.
- req pulses during LOAD and SHUFFLE: no card_valid. ready timing is unchanged at R+104.
- Reset asserted at R+60 (mid-SHUFFLE): all outputs return to reset values immediately and the state is IDLE. A new 6-cycle hold reproduces the first scenario.

Source files
------------

// File: rtl/blackjack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : blackjack_pkg                                                |
// | Description : Shared constants and the deck controller state encoding.     |
// |               DECK_SIZE/RANK_W/SEED_W size the deck datapath; LFSR_TAPS    |
// |               is the Galois mask for x^8+x^6+x^5+x^4+1; DEFAULT_SEED       |
// |               replaces an all-zero seed.                                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package blackjack_pkg;

  localparam int DECK_SIZE = 52;
  localparam int RANK_W    = 4;
  localparam int SEED_W    = 8;
  localparam int IDX_W     = 6;
  localparam int NUM_RANKS = 13;

  localparam logic [SEED_W-1:0] LFSR_TAPS    = 8'hB8;
  localparam logic [SEED_W-1:0] DEFAULT_SEED = 8'hA5;
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(DECK_SIZE - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SHUFFLE = 3'd3,
    ST_READY   = 3'd4,
    ST_EMPTY   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lfsr8                                                        |
// | Description : 8-bit right-shifting Galois LFSR used as the shuffle random  |
// |               source. A zero seed is replaced by DEFAULT_SEED so the       |
// |               register never locks up.                                     |
// | Ports       : clk  - clock                                                 |
// |               rst  - asynchronous active-low reset                         |
// |               load - load seed (priority over step)                        |
// |               seed - value to load                                         |
// |               step - advance one LFSR state                                |
// |               q    - current LFSR value                                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module lfsr8
  import blackjack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [SEED_W-1:0] seed,
  input  logic              step,
  output logic [SEED_W-1:0] q
);

  logic [SEED_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= DEFAULT_SEED;
    end else if (load) begin
      r_q <= (seed == '0) ? DEFAULT_SEED : seed;
    end else if (step) begin
      // Shift right; when the bit falling out is 1, fold in the tap mask.
      r_q <= {1'b0, r_q[SEED_W-1:1]} ^ (r_q[0] ? LFSR_TAPS : '0);
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/deck_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : deck_controller                                              |
// | Description : Captures a shuffle seed from the seed button hold time,      |
// |               loads a 52-card deck in rank order, performs an in-place     |
// |               LFSR-driven Fisher-Yates shuffle and deals one card per      |
// |               request until the deck is exhausted.                         |
// | Ports       : clk        - clock                                           |
// |               rst        - asynchronous active-low reset                   |
// |               seed_hold  - active-low seed button (debounced)              |
// |               req        - card request from the game FSM                  |
// |               card       - rank of the dealt card (1..13)                  |
// |               card_valid - one-cycle pulse qualifying card                 |
// |               ready      - deck shuffled, cards remain                     |
// |               busy       - loading or shuffling                            |
// |               empty      - every card has been dealt                       |
// |               cards_left - cards remaining                                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module deck_controller
  import blackjack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_hold,
  input  logic              req,
  output logic [RANK_W-1:0] card,
  output logic              card_valid,
  output logic              ready,
  output logic              busy,
  output logic              empty,
  output logic [IDX_W-1:0]  cards_left
);

  state_t             r_state;
  logic [SEED_W-1:0]  r_seed;
  logic [IDX_W-1:0]   r_idx;     // LOAD write index, then SHUFFLE swap index i
  logic [RANK_W-1:0]  r_rank;    // (r_idx mod 13)+1 tracked incrementally
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_left;
  logic [RANK_W-1:0]  r_card;
  logic               r_valid;
  logic               r_ready;
  logic               r_busy;
  logic               r_empty;
  logic [RANK_W-1:0]  r_deck [DECK_SIZE];

  logic               w_lfsr_load;
  logic               w_lfsr_step;
  logic [SEED_W-1:0]  w_lfsr_q;
  logic [SEED_W-1:0]  w_div;
  logic [IDX_W-1:0]   w_j;

  // The LFSR is seeded on the release edge so it holds the seed on the
  // first LOAD cycle; it only advances during SHUFFLE, once per swap.
  assign w_lfsr_load = (r_state == ST_SEED) && seed_hold;
  assign w_lfsr_step = (r_state == ST_SHUFFLE);

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (w_lfsr_load),
    .seed (r_seed),
    .step (w_lfsr_step),
    .q    (w_lfsr_q)
  );

  // Swap partner j = r mod (i+1); always <= i, so it fits the index width.
  assign w_div = SEED_W'(r_idx) + SEED_W'(1);
  assign w_j   = IDX_W'(w_lfsr_q % w_div);

  // Deck storage: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD) begin
      r_deck[r_idx] <= r_rank;
    end else if (r_state == ST_SHUFFLE) begin
      r_deck[r_idx] <= r_deck[w_j];
      r_deck[w_j]   <= r_deck[r_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_seed  <= '0;
      r_idx   <= '0;
      r_rank  <= RANK_W'(1);
      r_ptr   <= '0;
      r_left  <= '0;
      r_card  <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_empty <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!seed_hold) begin
            r_seed  <= r_seed + SEED_W'(1);
            r_state <= ST_SEED;
          end
        end
        ST_SEED: begin
          if (!seed_hold) begin
            r_seed <= r_seed + SEED_W'(1);
          end else begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_rank  <= RANK_W'(1);
          end
        end
        ST_LOAD: begin
          // r_idx is left at the last entry: that is the first swap index.
          if (r_idx == LAST_IDX) begin
            r_state <= ST_SHUFFLE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
          r_rank <= (r_rank == RANK_W'(NUM_RANKS)) ? RANK_W'(1) : r_rank + RANK_W'(1);
        end
        ST_SHUFFLE: begin
          if (r_idx == IDX_W'(1)) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_left  <= IDX_W'(DECK_SIZE);
            r_ptr   <= '0;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        ST_READY: begin
          if (req) begin
            r_card  <= r_deck[r_ptr];
            r_valid <= 1'b1;
            r_ptr   <= r_ptr + IDX_W'(1);
            r_left  <= r_left - IDX_W'(1);
            if (r_left == IDX_W'(1)) begin
              r_state <= ST_EMPTY;
              r_ready <= 1'b0;
              r_empty <= 1'b1;
            end
          end
        end
        ST_EMPTY: begin
          r_state <= ST_EMPTY;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign card       = r_card;
  assign card_valid = r_valid;
  assign ready      = r_ready;
  assign busy       = r_busy;
  assign empty      = r_empty;
  assign cards_left = r_left;

endmodule
`default_nettype wire

// File: tb/tb_deck_controller.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_deck_controller                                           |
// | Description : Self-checking bench for deck_controller. A reference model   |
// |               builds the expected shuffled deck from the seed with plain   |
// |               integer arithmetic; directed and randomized scenarios are    |
// |               compared against it.                                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_deck_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       seed_hold = 1'b1;
  logic       req = 1'b0;
  logic [3:0] card;
  logic       card_valid;
  logic       ready;
  logic       busy;
  logic       empty;
  logic [5:0] cards_left;

  int checks = 0;
  int errors = 0;
  int mdeck [52];
  int got   [52];
  int seq6  [52];
  int seqa  [52];

  always #5 clk = ~clk;

  deck_controller dut (
    .clk        (clk),
    .rst        (rst),
    .seed_hold  (seed_hold),
    .req        (req),
    .card       (card),
    .card_valid (card_valid),
    .ready      (ready),
    .busy       (busy),
    .empty      (empty),
    .cards_left (cards_left)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: ordered deck, then Fisher-Yates driven by the Galois LFSR.
  function automatic void build_model(input int seed);
    int lfsr, j, t;
    lfsr = seed % 256;
    if (lfsr == 0) lfsr = 165;
    for (int i = 0; i < 52; i++) mdeck[i] = (i % 13) + 1;
    for (int i = 51; i >= 1; i--) begin
      j = lfsr % (i + 1);
      t = mdeck[i]; mdeck[i] = mdeck[j]; mdeck[j] = t;
      lfsr = (lfsr % 2 == 1) ? ((lfsr / 2) ^ 184) : (lfsr / 2);
    end
  endfunction

  task automatic do_reset();
    req = 1'b0;
    seed_hold = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_card"}, card, 0);
    chk({tag, "_valid"}, card_valid, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_empty"}, empty, 0);
    chk({tag, "_left"}, cards_left, 0);
  endtask

  // Hold the button for 'hold' sampled cycles, release, and time busy/ready.
  task automatic run_shuffle(input int hold, input bit noise);
    int busy_cnt, rise;
    seed_hold = 1'b0;
    repeat (hold) tick();
    seed_hold = 1'b1;
    busy_cnt = 0;
    rise = 0;
    for (int t = 1; t <= 300 && rise == 0; t++) begin
      if (noise) req = ($urandom_range(0, 1) == 1);
      tick();
      if (busy) busy_cnt++;
      if (noise) chk("valid_while_busy", card_valid, 0);
      if (ready) rise = t;
    end
    req = 1'b0;
    chk("busy_cycles", busy_cnt, 103);
    chk("ready_rise", rise, 104);
    chk("cards_left_full", cards_left, 52);
  endtask

  // Back-to-back requests: 53 requests, 52 pulses, compare with the model.
  task automatic deal_b2b();
    int pulses;
    int hist [14];
    for (int r = 0; r < 14; r++) hist[r] = 0;
    pulses = 0;
    req = 1'b1;
    for (int t = 1; t <= 53; t++) begin
      tick();
      if (card_valid) begin
        if (pulses < 52) got[pulses] = int'(card);
        pulses++;
        if (pulses == 52) begin
          chk("last_empty", empty, 1);
          chk("last_ready", ready, 0);
          chk("last_left", cards_left, 0);
        end
      end
      if (t == 53) chk("no_53rd_pulse", card_valid, 0);
    end
    req = 1'b0;
    chk("pulse_count", pulses, 52);
    for (int i = 0; i < 52; i++) begin
      chk($sformatf("card[%0d]", i), got[i], mdeck[i]);
      if (got[i] >= 1 && got[i] <= 13) hist[got[i]]++;
    end
    for (int r = 1; r <= 13; r++) chk($sformatf("rank%0d_count", r), hist[r], 4);
  endtask

  // Random request gaps: every accepted request must yield the next card.
  task automatic deal_random();
    int left;
    bit r;
    left = 52;
    for (int t = 0; t < 2000 && left > 0; t++) begin
      r = ($urandom_range(0, 2) != 0);
      req = r;
      tick();
      if (r) begin
        chk("rnd_valid", card_valid, 1);
        chk("rnd_card", card, mdeck[52 - left]);
        left--;
        chk("rnd_left", cards_left, left);
      end else begin
        chk("rnd_idle", card_valid, 0);
      end
    end
    req = 1'b0;
    chk("rnd_all_dealt", left, 0);
    chk("rnd_empty", empty, 1);
  endtask

  initial begin
    int diff, hold;

    // Reset state
    #2;
    check_reset_outputs("reset");
    do_reset();
    check_reset_outputs("post_reset");

    // Seed 6, back-to-back deal
    build_model(6);
    run_shuffle(6, 1'b0);
    deal_b2b();
    for (int i = 0; i < 52; i++) seq6[i] = got[i];

    // Same seed across a reset reproduces the sequence
    do_reset();
    run_shuffle(6, 1'b0);
    deal_b2b();
    diff = 0;
    for (int i = 0; i < 52; i++) if (got[i] != seq6[i]) diff++;
    chk("seed6_repeat_diffs", diff, 0);

    // Seed 7 yields a different sequence
    do_reset();
    build_model(7);
    run_shuffle(7, 1'b0);
    deal_b2b();
    diff = 0;
    for (int i = 0; i < 52; i++) if (got[i] != seq6[i]) diff++;
    chk("seed7_differs", (diff > 0), 1);

    // Wrap to zero (256) matches the default seed (165)
    do_reset();
    build_model(165);
    run_shuffle(256, 1'b0);
    deal_b2b();
    for (int i = 0; i < 52; i++) seqa[i] = got[i];
    do_reset();
    run_shuffle(165, 1'b0);
    deal_b2b();
    diff = 0;
    for (int i = 0; i < 52; i++) if (got[i] != seqa[i]) diff++;
    chk("wrap_vs_a5_diffs", diff, 0);

    // Requests during LOAD/SHUFFLE are ignored; timing unchanged
    do_reset();
    build_model(6);
    run_shuffle(6, 1'b1);
    deal_b2b();

    // Reset mid-shuffle at R+60
    do_reset();
    seed_hold = 1'b0;
    repeat (6) tick();
    seed_hold = 1'b1;
    repeat (60) tick();
    chk("mid_shuffle_busy", busy, 1);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("idle_after_reset_busy", busy, 0);
    chk("idle_after_reset_ready", ready, 0);
    build_model(6);
    run_shuffle(6, 1'b0);
    deal_b2b();
    diff = 0;
    for (int i = 0; i < 52; i++) if (got[i] != seq6[i]) diff++;
    chk("after_abort_diffs", diff, 0);

    // Randomized seeds, noisy requests while busy, random request gaps
    for (int k = 0; k < 4; k++) begin
      do_reset();
      hold = $urandom_range(1, 300);
      build_model(hold % 256);
      run_shuffle(hold, 1'b1);
      deal_random();
      req = 1'b1;
      tick();
      chk("empty_ignores_req", card_valid, 0);
      req = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
